mips_alu: RTL and testbench

// - 32-bit MIPS-style integer ALU for the EXE stage: arithmetic, logic, compare, shifts, LUI, HI/LO moves, mult/div.
// - Datapath is purely combinational. EXE feeds forwarded operands A/B and its architectural HI/LO.
// - EXE latches aluResult, HI_OUT and LO_OUT at its own clock edge.
// - Only the sticky overflow flag is clocked.

---
 rtl/mips_alu.sv | 182 ++++++++++++++++++
 tb/tb_mips_alu.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mips_alu.sv
// 32-bit MIPS-style EXE-stage ALU: combinational datapath plus a sticky signed-overflow flag.
// Define ALU_MULTDIV_EN to build the MULT/MULTU/DIV/DIVU hardware (opcodes 11-14).
module mips_alu (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [5:0]  ALU_control,
  input  logic [4:0]  shiftAmount,
  input  logic [31:0] HI_IN,
  input  logic [31:0] LO_IN,
  output logic [31:0] aluResult,
  output logic [31:0] HI_OUT,
  output logic [31:0] LO_OUT,
  output logic        overflow,
  output logic        ovf_sticky
);

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_ADDU  = 6'h01;
  localparam logic [5:0] OP_SUB   = 6'h02;
  localparam logic [5:0] OP_SUBU  = 6'h03;
  localparam logic [5:0] OP_AND   = 6'h04;
  localparam logic [5:0] OP_OR    = 6'h05;
  localparam logic [5:0] OP_XOR   = 6'h06;
  localparam logic [5:0] OP_NOR   = 6'h07;
  localparam logic [5:0] OP_SLT   = 6'h08;
  localparam logic [5:0] OP_SLTU  = 6'h09;
  localparam logic [5:0] OP_SLL   = 6'h0A;
  localparam logic [5:0] OP_SRL   = 6'h0B;
  localparam logic [5:0] OP_SRA   = 6'h0C;
  localparam logic [5:0] OP_SLLV  = 6'h0D;
  localparam logic [5:0] OP_SRLV  = 6'h0E;
  localparam logic [5:0] OP_SRAV  = 6'h0F;
  localparam logic [5:0] OP_LUI   = 6'h10;
  localparam logic [5:0] OP_MULT  = 6'h11;
  localparam logic [5:0] OP_MULTU = 6'h12;
  localparam logic [5:0] OP_DIV   = 6'h13;
  localparam logic [5:0] OP_DIVU  = 6'h14;
  localparam logic [5:0] OP_MFHI  = 6'h15;
  localparam logic [5:0] OP_MFLO  = 6'h16;
  localparam logic [5:0] OP_MTHI  = 6'h17;
  localparam logic [5:0] OP_MTLO  = 6'h18;
  localparam logic [5:0] OP_PASSA = 6'h19;
  localparam logic [5:0] OP_PASSB = 6'h1A;

  logic [31:0] add_s;
  logic [31:0] sub_s;
  logic [31:0] result_s;
  logic [31:0] hi_s;
  logic [31:0] lo_s;
  logic        ovf_s;
  logic        ovf_sticky_r;
  logic [4:0]  var_sh_s;

  assign add_s    = A + B;
  assign sub_s    = A - B;
  assign var_sh_s = A[4:0];

`ifdef ALU_MULTDIV_EN
  logic signed [63:0] smul_s;
  logic        [63:0] umul_s;
  logic        [31:0] sdiv_q_s;
  logic        [31:0] sdiv_r_s;
  logic        [31:0] udiv_q_s;
  logic        [31:0] udiv_r_s;

  assign smul_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign umul_s = {32'h0000_0000, A} * {32'h0000_0000, B};

  // Divider: zero divisor and the INT_MIN/-1 case are pinned so the operators never see them.
  always_comb begin
    sdiv_q_s = 32'hFFFF_FFFF;
    sdiv_r_s = A;
    udiv_q_s = 32'hFFFF_FFFF;
    udiv_r_s = A;
    if (B == 32'h0000_0000) begin
      sdiv_q_s = 32'hFFFF_FFFF;
      sdiv_r_s = A;
      udiv_q_s = 32'hFFFF_FFFF;
      udiv_r_s = A;
    end else begin
      udiv_q_s = A / B;
      udiv_r_s = A % B;
      if ((A == 32'h8000_0000) && (B == 32'hFFFF_FFFF)) begin
        sdiv_q_s = 32'h8000_0000;
        sdiv_r_s = 32'h0000_0000;
      end else begin
        sdiv_q_s = $unsigned($signed(A) / $signed(B));
        sdiv_r_s = $unsigned($signed(A) % $signed(B));
      end
    end
  end
`endif

  // Operation decode: result, next HI/LO and signed overflow.
  always_comb begin
    result_s = 32'h0000_0000;
    hi_s     = HI_IN;
    lo_s     = LO_IN;
    ovf_s    = 1'b0;
    case (ALU_control)
      OP_ADD: begin
        result_s = add_s;
        ovf_s    = (A[31] == B[31]) && (add_s[31] != A[31]);
      end
      OP_ADDU:  result_s = add_s;
      OP_SUB: begin
        result_s = sub_s;
        ovf_s    = (A[31] != B[31]) && (sub_s[31] != A[31]);
      end
      OP_SUBU:  result_s = sub_s;
      OP_AND:   result_s = A & B;
      OP_OR:    result_s = A | B;
      OP_XOR:   result_s = A ^ B;
      OP_NOR:   result_s = ~(A | B);
      OP_SLT:   result_s = {31'h0000_0000, ($signed(A) < $signed(B))};
      OP_SLTU:  result_s = {31'h0000_0000, (A < B)};
      OP_SLL:   result_s = B << shiftAmount;
      OP_SRL:   result_s = B >> shiftAmount;
      OP_SRA:   result_s = $unsigned($signed(B) >>> shiftAmount);
      OP_SLLV:  result_s = B << var_sh_s;
      OP_SRLV:  result_s = B >> var_sh_s;
      OP_SRAV:  result_s = $unsigned($signed(B) >>> var_sh_s);
      OP_LUI:   result_s = {B[15:0], 16'h0000};
`ifdef ALU_MULTDIV_EN
      OP_MULT: begin
        hi_s = smul_s[63:32];
        lo_s = smul_s[31:0];
      end
      OP_MULTU: begin
        hi_s = umul_s[63:32];
        lo_s = umul_s[31:0];
      end
      OP_DIV: begin
        hi_s = sdiv_r_s;
        lo_s = sdiv_q_s;
      end
      OP_DIVU: begin
        hi_s = udiv_r_s;
        lo_s = udiv_q_s;
      end
`else
      // Without the mult/div unit these opcodes are architectural no-ops.
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
        hi_s = HI_IN;
        lo_s = LO_IN;
      end
`endif
      OP_MFHI:  result_s = HI_IN;
      OP_MFLO:  result_s = LO_IN;
      OP_MTHI:  hi_s     = A;
      OP_MTLO:  lo_s     = A;
      OP_PASSA: result_s = A;
      OP_PASSB: result_s = B;
      default: begin
        result_s = 32'h0000_0000;
        hi_s     = HI_IN;
        lo_s     = LO_IN;
        ovf_s    = 1'b0;
      end
    endcase
  end

  // Sticky overflow: set by any overflowing cycle, cleared only by reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ovf_sticky_r <= 1'b0;
    end else if (ovf_s) begin
      ovf_sticky_r <= 1'b1;
    end else begin
      ovf_sticky_r <= ovf_sticky_r;
    end
  end

  assign aluResult  = result_s;
  assign HI_OUT     = hi_s;
  assign LO_OUT     = lo_s;
  assign overflow   = ovf_s;
  assign ovf_sticky = ovf_sticky_r;

endmodule

// File: tb/tb_mips_alu.sv
// Scoreboard bench for mips_alu: stimulus pushes expectations, a monitor pops and compares.
module tb_mips_alu;

  logic        CLK;
  logic        RESET;
  logic [31:0] A;
  logic [31:0] B;
  logic [5:0]  ALU_control;
  logic [4:0]  shiftAmount;
  logic [31:0] HI_IN;
  logic [31:0] LO_IN;
  logic [31:0] aluResult;
  logic [31:0] HI_OUT;
  logic [31:0] LO_OUT;
  logic        overflow;
  logic        ovf_sticky;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ovf;
    logic        sticky;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;
  int   popped = 0;
  logic sticky_model = 1'b0;

  localparam logic [31:0] HDEF = 32'hAAAA_0000;
  localparam logic [31:0] LDEF = 32'h0000_BBBB;

  mips_alu dut (
    .CLK(CLK), .RESET(RESET), .A(A), .B(B), .ALU_control(ALU_control),
    .shiftAmount(shiftAmount), .HI_IN(HI_IN), .LO_IN(LO_IN),
    .aluResult(aluResult), .HI_OUT(HI_OUT), .LO_OUT(LO_OUT),
    .overflow(overflow), .ovf_sticky(ovf_sticky)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %08h expected %08h", nm, fld, act, req);
    end
  endtask

  // Monitor: every sample strobe pops one expectation and compares all outputs.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: sample with empty queue got 0 expected 1");
      end else begin
        e = exp_q.pop_front();
        popped++;
        chk(e.name, "aluResult", aluResult, e.res);
        chk(e.name, "HI_OUT", HI_OUT, e.hi);
        chk(e.name, "LO_OUT", LO_OUT, e.lo);
        chk(e.name, "overflow", {31'h0, overflow}, {31'h0, e.ovf});
        chk(e.name, "ovf_sticky", {31'h0, ovf_sticky}, {31'h0, e.sticky});
      end
    end
  end

  task automatic push_and_sample(input string nm, input logic [31:0] r, input logic [31:0] h,
                                 input logic [31:0] l, input logic o);
    exp_t e;
    e.name = nm; e.res = r; e.hi = h; e.lo = l; e.ovf = o; e.sticky = sticky_model;
    exp_q.push_back(e);
    -> sample_ev;
    #1;
  endtask

  // Drive at negedge, sample 1 time unit later, then fold overflow into the sticky model for the next posedge.
  task automatic apply(input string nm, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] hi, input logic [31:0] lo,
                       input logic [31:0] r, input logic [31:0] eh, input logic [31:0] el, input logic o);
    @(negedge CLK);
    ALU_control = op; A = a; B = b; shiftAmount = sh; HI_IN = hi; LO_IN = lo;
    #1;
    push_and_sample(nm, r, eh, el, o);
    if (RESET) sticky_model = sticky_model | o;
  endtask

  initial begin
    RESET = 1'b0;
    A = 32'h0; B = 32'h0; ALU_control = 6'h00; shiftAmount = 5'd0; HI_IN = HDEF; LO_IN = LDEF;

    apply("reset", 6'h00, 32'h0, 32'h0, 5'd0, HDEF, LDEF, 32'h0, HDEF, LDEF, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;

    apply("add_ovf",  6'h00, 32'h7FFF_FFFF, 32'h1, 5'd0, HDEF, LDEF, 32'h8000_0000, HDEF, LDEF, 1'b1);
    apply("addu",     6'h01, 32'h7FFF_FFFF, 32'h1, 5'd0, HDEF, LDEF, 32'h8000_0000, HDEF, LDEF, 1'b0);
    apply("sub_ovf",  6'h02, 32'h8000_0000, 32'h1, 5'd0, HDEF, LDEF, 32'h7FFF_FFFF, HDEF, LDEF, 1'b1);
    apply("sub",      6'h02, 32'h5, 32'h3, 5'd0, HDEF, LDEF, 32'h2, HDEF, LDEF, 1'b0);
    apply("subu",     6'h03, 32'h0, 32'h1, 5'd0, HDEF, LDEF, 32'hFFFF_FFFF, HDEF, LDEF, 1'b0);
    apply("add_wrap", 6'h00, 32'hFFFF_FFFF, 32'h1, 5'd0, HDEF, LDEF, 32'h0, HDEF, LDEF, 1'b0);
    apply("and",      6'h04, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, HDEF, LDEF, 32'hF000_F000, HDEF, LDEF, 1'b0);
    apply("or",       6'h05, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, HDEF, LDEF, 32'hFFF0_FFF0, HDEF, LDEF, 1'b0);
    apply("xor",      6'h06, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, HDEF, LDEF, 32'h0FF0_0FF0, HDEF, LDEF, 1'b0);
    apply("nor",      6'h07, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, HDEF, LDEF, 32'h000F_000F, HDEF, LDEF, 1'b0);
    apply("slt",      6'h08, 32'hFFFF_FFFF, 32'h1, 5'd0, HDEF, LDEF, 32'h1, HDEF, LDEF, 1'b0);
    apply("sltu",     6'h09, 32'hFFFF_FFFF, 32'h1, 5'd0, HDEF, LDEF, 32'h0, HDEF, LDEF, 1'b0);
    apply("sll",      6'h0A, 32'h0, 32'h1, 5'd31, HDEF, LDEF, 32'h8000_0000, HDEF, LDEF, 1'b0);
    apply("srl",      6'h0B, 32'h0, 32'h8000_0000, 5'd4, HDEF, LDEF, 32'h0800_0000, HDEF, LDEF, 1'b0);
    apply("sra",      6'h0C, 32'h0, 32'h8000_0000, 5'd4, HDEF, LDEF, 32'hF800_0000, HDEF, LDEF, 1'b0);
    apply("sllv",     6'h0D, 32'h21, 32'h1, 5'd7, HDEF, LDEF, 32'h2, HDEF, LDEF, 1'b0);
    apply("srlv",     6'h0E, 32'h4, 32'h8000_0000, 5'd0, HDEF, LDEF, 32'h0800_0000, HDEF, LDEF, 1'b0);
    apply("srav",     6'h0F, 32'h24, 32'h8000_0000, 5'd0, HDEF, LDEF, 32'hF800_0000, HDEF, LDEF, 1'b0);
    apply("lui",      6'h10, 32'h1234_5678, 32'h0000_ABCD, 5'd0, HDEF, LDEF, 32'hABCD_0000, HDEF, LDEF, 1'b0);
`ifdef ALU_MULTDIV_EN
    apply("mult",     6'h11, 32'hFFFF_FFFE, 32'h3, 5'd0, HDEF, LDEF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    apply("multu",    6'h12, 32'hFFFF_FFFE, 32'h3, 5'd0, HDEF, LDEF, 32'h0, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
    apply("div",      6'h13, 32'hFFFF_FFF9, 32'h2, 5'd0, HDEF, LDEF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    apply("div_min",  6'h13, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, HDEF, LDEF, 32'h0, 32'h0, 32'h8000_0000, 1'b0);
    apply("div_z",    6'h13, 32'h7, 32'h0, 5'd0, HDEF, LDEF, 32'h0, 32'h7, 32'hFFFF_FFFF, 1'b0);
    apply("divu",     6'h14, 32'h7, 32'h2, 5'd0, HDEF, LDEF, 32'h0, 32'h1, 32'h3, 1'b0);
    apply("divu_z",   6'h14, 32'h5, 32'h0, 5'd0, HDEF, LDEF, 32'h0, 32'h5, 32'hFFFF_FFFF, 1'b0);
`else
    apply("mult",     6'h11, 32'hFFFF_FFFE, 32'h3, 5'd0, HDEF, LDEF, 32'h0, HDEF, LDEF, 1'b0);
    apply("multu",    6'h12, 32'hFFFF_FFFE, 32'h3, 5'd0, HDEF, LDEF, 32'h0, HDEF, LDEF, 1'b0);
    apply("div",      6'h13, 32'hFFFF_FFF9, 32'h2, 5'd0, HDEF, LDEF, 32'h0, HDEF, LDEF, 1'b0);
    apply("divu_z",   6'h14, 32'h5, 32'h0, 5'd0, HDEF, LDEF, 32'h0, HDEF, LDEF, 1'b0);
`endif
    apply("mflo",     6'h16, 32'h0, 32'h0, 5'd0, HDEF, 32'h0BAD_F00D, 32'h0BAD_F00D, HDEF, 32'h0BAD_F00D, 1'b0);
    apply("mthi",     6'h17, 32'hDEAD_BEEF, 32'h1, 5'd0, HDEF, LDEF, 32'h0, 32'hDEAD_BEEF, LDEF, 1'b0);
    apply("mtlo",     6'h18, 32'hCAFE_0001, 32'h1, 5'd0, HDEF, LDEF, 32'h0, HDEF, 32'hCAFE_0001, 1'b0);
    apply("passa",    6'h19, 32'h1357_9BDF, 32'h2468_ACE0, 5'd0, HDEF, LDEF, 32'h1357_9BDF, HDEF, LDEF, 1'b0);
    apply("passb",    6'h1A, 32'h1357_9BDF, 32'h2468_ACE0, 5'd0, HDEF, LDEF, 32'h2468_ACE0, HDEF, LDEF, 1'b0);
    apply("op_1b",    6'h1B, 32'h1357_9BDF, 32'h2468_ACE0, 5'd3, HDEF, LDEF, 32'h0, HDEF, LDEF, 1'b0);
    apply("op_3f",    6'h3F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, HDEF, LDEF, 32'h0, HDEF, LDEF, 1'b0);
    apply("mfhi",     6'h15, 32'h0, 32'h0, 5'd0, 32'h1234_5678, LDEF, 32'h1234_5678, 32'h1234_5678, LDEF, 1'b0);

    // Asynchronous reset asserted mid-cycle clears the sticky flag without a clock edge.
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    sticky_model = 1'b0;
    #1;
    push_and_sample("async_rst", 32'h1234_5678, 32'h1234_5678, LDEF, 1'b0);
    #1;
    RESET = 1'b1;
    apply("post_rst", 6'h00, 32'h1, 32'h1, 5'd0, HDEF, LDEF, 32'h2, HDEF, LDEF, 1'b0);

    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: left %0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: popped %0d entries before time limit", popped);
    $fatal(1, "timeout");
  end

endmodule
